// File: rtl/poly_op_sequencer.sv
// Micro-sequencer stepping through a stored list of polynomial-unit ops.
// Optional per-op watchdog: define POLY_SEQ_TIMEOUT_EN.
module poly_op_sequencer #(
  parameter int DEPTH          = 16,
  parameter int NUM_UNITS      = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [11:0]   prog_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [3:0]    unit_start,
  input  logic [3:0]    unit_done,
  output logic [2:0]    sel_a,
  output logic [2:0]    sel_b,
  output logic [2:0]    sel_dst,
  output logic [AW-1:0] pc
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, FINISH} state_t;

  state_t      state, state_nx;
  logic [11:0] mem [DEPTH];
  logic [11:0] op;
  logic        op_valid;
  logic        unit_hit;
  logic        at_end;
  logic        timeout;

  assign op_valid = (int'(op[10:9]) < NUM_UNITS);
  // A done coinciding with our own start pulse belongs to an earlier op.
  assign unit_hit = unit_done[op[10:9]] && (unit_start == 4'b0000);
  assign at_end   = op[11] || (pc == AW'(DEPTH - 1));

`ifdef POLY_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wcnt;

  assign timeout = (state == WAIT) && (wcnt == TW'(TIMEOUT_CYCLES - 1)) && !unit_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (state == ISSUE) begin
      wcnt <= '0;
    end else if (state == WAIT) begin
      wcnt <= wcnt + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   state_nx = ISSUE;
      ISSUE:   state_nx = op_valid ? WAIT : FINISH;
      WAIT: begin
        if (unit_hit) begin
          state_nx = at_end ? FINISH : FETCH;
        end else if (timeout) begin
          state_nx = FINISH;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      unit_start <= 4'b0000;
      sel_a      <= 3'd0;
      sel_b      <= 3'd0;
      sel_dst    <= 3'd0;
      pc         <= '0;
      op         <= 12'd0;
    end else begin
      state      <= state_nx;
      done       <= 1'b0;
      err        <= 1'b0;
      unit_start <= 4'b0000;
      case (state)
        IDLE: begin
          if (start) begin
            pc   <= '0;
            busy <= 1'b1;
          end
        end
        FETCH: op <= mem[pc];
        ISSUE: begin
          if (op_valid) begin
            sel_a      <= op[8:6];
            sel_b      <= op[5:3];
            sel_dst    <= op[2:0];
            unit_start <= 4'b0001 << op[10:9];
          end
        end
        WAIT: begin
          if (unit_hit && !at_end) pc <= pc + AW'(1);
        end
        default: ;
      endcase
      // Only a bad unit index or a watchdog expiry reaches FINISH without unit_hit.
      if (state_nx == FINISH) begin
        done <= 1'b1;
        err  <= (state == ISSUE) || ((state == WAIT) && !unit_hit);
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poly_op_sequencer.sv
// Directed self-checking bench for poly_op_sequencer (NUM_UNITS=3, TIMEOUT_CYCLES=8).
module tb_poly_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [11:0] prog_data = 12'd0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [3:0]  unit_start;
  logic [3:0]  unit_done;
  logic [3:0]  resp_done = 4'b0000;
  logic [3:0]  man_done = 4'b0000;
  logic [2:0]  sel_a, sel_b, sel_dst;
  logic [3:0]  pc;

  int checks = 0;
  int failures = 0;

  // monitor / responder state
  int         cyc = 0;
  int         n_starts = 0, n_done = 0, n_err = 0, n_err_alone = 0;
  int         start_cyc = 0, done_cyc = 0;
  logic [3:0] pc_at_done = 4'd0;
  logic [3:0] start_log [64];
  bit         auto_resp = 1'b0;
  int         lat = 10;
  int         resp_cnt = 0;
  logic [3:0] resp_unit = 4'b0000;

  int base_starts, base_done, base_err;

  assign unit_done = resp_done | man_done;

  always #5 clk = ~clk;

  poly_op_sequencer #(.DEPTH(16), .NUM_UNITS(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .busy(busy), .done(done), .err(err), .unit_start(unit_start),
    .unit_done(unit_done), .sel_a(sel_a), .sel_b(sel_b), .sel_dst(sel_dst), .pc(pc)
  );

  // Sample outputs mid-cycle; model each unit as answering lat cycles after its start.
  always @(negedge clk) begin
    cyc++;
    resp_done = 4'b0000;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_done = resp_unit;
    end
    if (unit_start != 4'b0000) begin
      if (n_starts < 64) start_log[n_starts] = unit_start;
      n_starts++;
      start_cyc = cyc;
      if (auto_resp) begin
        resp_cnt  = lat;
        resp_unit = unit_start;
      end
    end
    if (done) begin
      n_done++;
      done_cyc   = cyc;
      pc_at_done = pc;
      if (err) n_err++;
    end
    if (err && !done) n_err_alone++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] mk(input bit last, input logic [1:0] unit,
                                     input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
    return {last, unit, a, b, d};
  endfunction

  task automatic wr(input logic [3:0] addr, input logic [11:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic mark();
    base_starts = n_starts; base_done = n_done; base_err = n_err;
  endtask

  task automatic run();
    mark();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (n_done == base_done && k < max) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, n_done - base_done, 1);
  endtask

  task automatic wait_starts(input string tag, input int cnt, input int max);
    int k = 0;
    while (n_starts - base_starts < cnt && k < max) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, n_starts - base_starts, cnt);
  endtask

  task automatic load3();
    wr(4'd0, mk(1'b0, 2'd0, 3'd1, 3'd2, 3'd3));
    wr(4'd1, mk(1'b0, 2'd1, 3'd4, 3'd5, 3'd6));
    wr(4'd2, mk(1'b1, 2'd2, 3'd7, 3'd0, 3'd1));
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_ustart", unit_start, 0);
    check_eq("rst_sel", {sel_a, sel_b, sel_dst}, 0);
    check_eq("rst_pc", pc, 0);
    rst = 1'b0;

    // 1: three ops, units 0,1,2
    load3();
    auto_resp = 1'b1; lat = 10;
    run();
    check_eq("t1_busy_run", busy, 1);
    wait_done("t1_done", 200);
    check_eq("t1_nstarts", n_starts - base_starts, 3);
    check_eq("t1_start0", start_log[base_starts], 4'b0001);
    check_eq("t1_start1", start_log[base_starts + 1], 4'b0010);
    check_eq("t1_start2", start_log[base_starts + 2], 4'b0100);
    check_eq("t1_err", n_err - base_err, 0);
    check_eq("t1_sel_last", {sel_a, sel_b, sel_dst}, {3'd7, 3'd0, 3'd1});
    @(negedge clk);
    check_eq("t1_busy_after", busy, 0);

    // 2: foreign done pulses are ignored
    auto_resp = 1'b0;
    wr(4'd0, mk(1'b1, 2'd1, 3'd2, 3'd3, 3'd5));
    run();
    wait_starts("t2_start", 1, 20);
    check_eq("t2_ustart_id", start_log[base_starts], 4'b0010);
    repeat (2) @(negedge clk);
    man_done = 4'b0101;
    @(negedge clk);
    man_done = 4'b0000;
    repeat (3) @(negedge clk);
    check_eq("t2_still_busy", busy, 1);
    check_eq("t2_no_done", n_done - base_done, 0);
    check_eq("t2_sel_wait", {sel_a, sel_b, sel_dst}, {3'd2, 3'd3, 3'd5});
    man_done = 4'b0010;
    @(negedge clk);
    man_done = 4'b0000;
    wait_done("t2_done", 10);
    check_eq("t2_err", n_err - base_err, 0);
    check_eq("t2_sel_held", {sel_a, sel_b, sel_dst}, {3'd2, 3'd3, 3'd5});

    // 3: no last bit, stops at DEPTH-1
    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      wr(iv, mk(1'b0, 2'd0, iv[2:0], ~iv[2:0], 3'(iv + 4'd1)));
    end
    auto_resp = 1'b1; lat = 2;
    run();
    wait_done("t3_done", 300);
    check_eq("t3_pc_end", pc_at_done, 4'd15);
    repeat (10) @(negedge clk);
    check_eq("t3_nstarts", n_starts - base_starts, 16);
    check_eq("t3_err", n_err - base_err, 0);

    // 4: unit index beyond NUM_UNITS
    wr(4'd0, mk(1'b0, 2'd3, 3'd1, 3'd1, 3'd1));
    run();
    wait_done("t4_done", 20);
    check_eq("t4_err_with_done", n_err - base_err, 1);
    check_eq("t4_no_start", n_starts - base_starts, 0);
    check_eq("t4_sel_kept", {sel_a, sel_b, sel_dst}, {3'd7, 3'd0, 3'd0});

    // 5: reset during WAIT of op 2
    load3();
    lat = 10;
    run();
    wait_starts("t5_two_starts", 2, 100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_busy_rst", busy, 0);
    repeat (12) @(negedge clk);
    check_eq("t5_no_done", n_done - base_done, 0);
    run();
    wait_done("t5_rerun_done", 200);
    check_eq("t5_rerun_starts", n_starts - base_starts, 3);
    check_eq("t5_rerun_first", start_log[base_starts], 4'b0001);
    check_eq("t5_rerun_err", n_err - base_err, 0);

`ifdef POLY_SEQ_TIMEOUT_EN
    // 6: watchdog expiry, and a done on the limit cycle
    auto_resp = 1'b0;
    wr(4'd0, mk(1'b1, 2'd0, 3'd1, 3'd2, 3'd3));
    run();
    wait_done("t6_to_done", 40);
    check_eq("t6_to_err", n_err - base_err, 1);
    check_eq("t6_to_delay", done_cyc - start_cyc, 8);
    auto_resp = 1'b1; lat = 7;
    run();
    wait_done("t6_edge_done", 40);
    check_eq("t6_edge_err", n_err - base_err, 0);
    check_eq("t6_edge_delay", done_cyc - start_cyc, 8);
`endif

    check_eq("err_without_done", n_err_alone, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
